stopwatch_counter: RTL
======================

// Module: stopwatch_counter
//
// PURPOSE
//   Timekeeping core of the stopwatch. Counts elapsed time as BCD digits
//   in the format M:SS.t, using tenths of a second as the base unit.
//   Produces the four hex digits consumed by the 4-digit display multiplexer
//   (hex3 = minutes ... hex0 = tenths). Start/stop/clear come from
//   debounced, single-cycle button pulses.
//
// PARAMETERS
//   TICK_COUNT  10_000_000  clock cycles per 0.1 s tick (100 MHz clock)
//   DIV_W       24          prescaler width; 2**DIV_W must be >= TICK_COUNT
//
// PORTS
//   clock       in   1  100 MHz system clock
//   reset       in   1  asynchronous, active-high reset
//   start_stop  in   1  1-cycle pulse: start / pause / resume
//   clear       in   1  1-cycle pulse: stop and zero all digits
//   lap         in   1  1-cycle pulse: toggle display hold (LAP_HOLD_EN only)
//   hex3        out  4  minutes digit, 0-9
//   hex2        out  4  seconds-tens digit, 0-5
//   hex1        out  4  seconds-ones digit, 0-9
//   hex0        out  4  tenths digit, 0-9
//   running     out  1  1 while in state RUN
//   lap_active  out  1  1 while the display is frozen
//   overflow    out  1  1-cycle pulse on the 9:59.9 -> 0:00.0 wrap
//
// BEHAVIOUR
//   Reset: state is IDLE; the prescaler and all digits are 0.
//     All outputs are 0.
//   FSM states: IDLE, RUN, PAUSE.
//     - IDLE  --start_stop--> RUN. The prescaler is zeroed on entry.
//     - RUN   --start_stop--> PAUSE
//     - PAUSE --start_stop--> RUN. The prescaler value is retained.
//     - clear from any state: next state is IDLE, digits and prescaler are
//       zeroed, and any lap hold is released.
//   Simultaneous events: clear beats start_stop and lap in the same cycle.
//   Prescaler: counts only in RUN. tick = (div == TICK_COUNT-1) && RUN.
//     On tick, div goes to 0.
//   Digit chain: each digit is a registered modulo counter with a carry:
//     - tenths mod 10 -> sec-ones mod 10 -> sec-tens mod 6 -> minutes mod 10.
//     - The digit value updates on the clock edge at which tick is high.
//     - All carries resolve within that same edge (no ripple latency).
//   Wrap: at 9:59.9 a tick sets the digits to 0:00.0.
//     - overflow is high for exactly that cycle.
//     - The counter stays in RUN.
//   Digits never show illegal values; hex2 never exceeds 5.
//   An asynchronous reset mid-count forces IDLE immediately; no pulse
//     is emitted.
//
// CONFIGURATION
//   Macro STOPWATCH_LAP_HOLD_EN, when defined:
//     - A lap pulse in RUN with no hold active captures the live digits into
//       hold registers and sets lap_active. hex3..0 then show the held value
//       while counting continues internally.
//     - A lap pulse while lap_active, or a start_stop into PAUSE, releases the
//       hold. From the next cycle the outputs show the live digits.
//     - A lap pulse in IDLE, or in PAUSE with no hold active, is ignored.
//   Macro not defined:
//     - The lap port is present but ignored.
//     - lap_active is tied to 0 and hex3..0 always show the live digits.
//
// STRUCTURE
//   stopwatch_pkg holds:
//     - state encodings ST_IDLE, ST_RUN, ST_PAUSE
//     - digit moduli TENTHS_MOD=10, SEC1_MOD=10, SEC10_MOD=6, MIN_MOD=10
//   Sub-module bcd_digit_counter (param MOD):
//     - inputs: clock, reset, clr, inc
//     - outputs: q[3:0], carry = inc && (q == MOD-1)
//     - instantiated four times, chained inc <- carry of the lower digit
//
// TESTING  (bench sets TICK_COUNT=4)
//   1. Reset, then start_stop; run 10 ticks -> hex = 0,0,1,0; running=1.
//   2. Run to 0:59.9, then 1 tick -> 1:00.0; hex2 never shows 6.
//   3. From 9:59.9, 1 tick -> 0:00.0, overflow high 1 cycle, running=1.
//   4. Pause at div=2, hold 20 cycles, resume -> next tick after 2 cycles.
//   5. clear + start_stop in the same cycle during RUN -> IDLE, digits 0.
//   6. (LAP_HOLD_EN) lap at 0:01.2, run 5 ticks -> hex frozen at 0:01.2;
//      lap again -> 0:01.7.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch timekeeping core:
// FSM state encodings and the modulus of each BCD digit.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  localparam int unsigned TENTHS_MOD = 10;
  localparam int unsigned SEC1_MOD   = 10;
  localparam int unsigned SEC10_MOD  = 6;
  localparam int unsigned MIN_MOD    = 10;

endpackage

// File: rtl/stopwatch_counter_bcd_digit_counter.sv
// One BCD digit of the stopwatch: a modulo-MOD counter that advances on inc
// and reports a carry in the same cycle it wraps, so a chain of these
// digits resolves every carry on a single clock edge.
module bcd_digit_counter #(
  parameter int unsigned MOD = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] q,
  output logic       carry
);

  localparam logic [3:0] MAX_VAL = 4'(MOD - 1);

  logic [3:0] q_q;
  logic [3:0] q_d;

  // Next digit value: clear dominates, otherwise wrap at MOD-1.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = 4'd0;
    end else if (inc) begin
      if (q_q == MAX_VAL) begin
        q_d = 4'd0;
      end else begin
        q_d = q_q + 4'd1;
      end
    end else begin
      q_d = q_q;
    end
  end

  // Digit register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q     = q_q;
  assign carry = inc && (q_q == MAX_VAL);

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch timekeeping core: IDLE/RUN/PAUSE control, 0.1 s prescaler and
// a four-digit M:SS.t BCD chain. Optional display hold (lap) is built when
// the macro STOPWATCH_LAP_HOLD_EN is defined; otherwise lap is ignored and
// lap_active stays 0.
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_COUNT = 10_000_000,
  parameter int unsigned DIV_W      = 24
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] hex3,
  output logic [3:0] hex2,
  output logic [3:0] hex1,
  output logic [3:0] hex0,
  output logic       running,
  output logic       lap_active,
  output logic       overflow
);

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               overflow_q, overflow_d;
  logic               tick_s;
  logic [3:0]         d0_s, d1_s, d2_s, d3_s;
  logic               c0_s, c1_s, c2_s, c3_s;
  logic [15:0]        live_s;

  assign tick_s = (state_q == ST_RUN) && (div_q == DIV_W'(TICK_COUNT - 1));

  // Control FSM and prescaler next-state; clear overrides every other input.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    if (clear) begin
      state_d = ST_IDLE;
      div_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          div_d = '0;
          if (start_stop) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (tick_s) begin
            div_d = '0;
          end else begin
            div_d = div_q + DIV_W'(1);
          end
          if (start_stop) begin
            state_d = ST_PAUSE;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_PAUSE: begin
          if (start_stop) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_PAUSE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          div_d   = '0;
        end
      endcase
    end
  end

  // Overflow is a one-cycle flag raised by the edge that wraps 9:59.9.
  always_comb begin
    if (clear) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = c3_s;
    end
  end

  // State, prescaler and overflow registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      div_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      overflow_q <= overflow_d;
    end
  end

  bcd_digit_counter #(.MOD(TENTHS_MOD)) u_tenths (
    .clock(clock), .reset(reset), .clr(clear), .inc(tick_s), .q(d0_s), .carry(c0_s)
  );
  bcd_digit_counter #(.MOD(SEC1_MOD)) u_sec1 (
    .clock(clock), .reset(reset), .clr(clear), .inc(c0_s), .q(d1_s), .carry(c1_s)
  );
  bcd_digit_counter #(.MOD(SEC10_MOD)) u_sec10 (
    .clock(clock), .reset(reset), .clr(clear), .inc(c1_s), .q(d2_s), .carry(c2_s)
  );
  bcd_digit_counter #(.MOD(MIN_MOD)) u_min (
    .clock(clock), .reset(reset), .clr(clear), .inc(c2_s), .q(d3_s), .carry(c3_s)
  );

  assign live_s   = {d3_s, d2_s, d1_s, d0_s};
  assign running  = (state_q == ST_RUN);
  assign overflow = overflow_q;

`ifdef STOPWATCH_LAP_HOLD_EN
  logic        hold_q, hold_d;
  logic [15:0] held_q, held_d;

  // Display hold: pausing or a second lap releases; a lap in RUN captures.
  always_comb begin
    hold_d = hold_q;
    held_d = held_q;
    if (clear) begin
      hold_d = 1'b0;
    end else if ((state_q == ST_RUN) && start_stop) begin
      hold_d = 1'b0;
    end else if (hold_q && lap) begin
      hold_d = 1'b0;
    end else if ((state_q == ST_RUN) && lap) begin
      hold_d = 1'b1;
      held_d = live_s;
    end else begin
      hold_d = hold_q;
    end
  end

  // Hold flag and captured digits.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_q <= 1'b0;
      held_q <= 16'd0;
    end else begin
      hold_q <= hold_d;
      held_q <= held_d;
    end
  end

  assign lap_active             = hold_q;
  assign {hex3, hex2, hex1, hex0} = hold_q ? held_q : live_s;
`else
  logic unused_lap_s;
  assign unused_lap_s           = lap;
  assign lap_active             = 1'b0;
  assign {hex3, hex2, hex1, hex0} = live_s;
`endif

endmodule
